// File: rtl/uart_rx_frame.sv
// UART receive deserializer: oversampled start/data/parity/stop framing with a frame-valid strobe.
// Define RX_MAJORITY_VOTE_EN to take each captured bit as a 2-of-3 vote over the last three baud ticks.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] raw_data,
    output logic                 start_bit,
    output logic                 parity_bit,
    output logic                 stop_bit,
    output logic                 recieved_flag,
    output logic                 rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic [CW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            fall_edge;
    logic            mid_bit;
    logic            sample;

    // rx_prev trails rx_s by one clock so the idle-to-start edge can be seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] sample_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_hist <= 2'b11;
        end else if (baud_tick) begin
            sample_hist <= {sample_hist[0], rx_s};
        end
    end

    assign sample = (rx_s & sample_hist[0]) | (rx_s & sample_hist[1]) |
                    (sample_hist[0] & sample_hist[1]);
`else
    assign sample = rx_s;
`endif

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The start bit is sampled half a bit after the edge; every later bit one full bit after that.
    always_comb begin
        fall_edge  = rx_prev & ~rx_s;
        mid_bit    = baud_tick && (tick_cnt == ((state == START) ? HALF_LAST : FULL_LAST));
        state_next = state;
        case (state)
            IDLE:    if (fall_edge) state_next = START;
            START:   if (mid_bit) state_next = DATA;
            DATA: begin
                if (mid_bit && (bit_cnt == LAST_BIT)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (mid_bit) state_next = STOP;
            STOP:    if (mid_bit) state_next = sample ? IDLE : BREAK;
            BREAK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            raw_data      <= '0;
            start_bit     <= 1'b0;
            parity_bit    <= 1'b0;
            stop_bit      <= 1'b1;
            recieved_flag <= 1'b0;
        end else begin
            recieved_flag <= 1'b0;
            if (state == IDLE) begin
                if (fall_edge) begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
            end else if (baud_tick && (state != BREAK)) begin
                tick_cnt <= mid_bit ? '0 : tick_cnt + 1'b1;
            end
            if (mid_bit) begin
                case (state)
                    START:  start_bit <= sample;
                    DATA: begin
                        raw_data[bit_cnt] <= sample;
                        bit_cnt           <= bit_cnt + 1'b1;
                    end
                    PARITY: parity_bit <= sample;
                    STOP: begin
                        stop_bit      <= sample;
                        recieved_flag <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: one parity and one no-parity instance, each on its own line,
// against a bit-level model of the serial frame and its expected sampling tick.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_p = 1'b1;
    logic       rx_n = 1'b1;
    logic [7:0] data_p, data_n;
    logic       start_p, par_p, stop_p, flag_p, busy_p;
    logic       start_n, par_n, stop_n, flag_n, busy_n;

    int         checks = 0;
    int         errors = 0;
    int         tick_no = 0;
    int         tick_div = 0;
    int         flag_cnt [2];
    logic [11:0] snap [2];
    int         snap_tick [2];

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .OVERSAMPLE(16)) dut_p (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_p),
        .raw_data(data_p), .start_bit(start_p), .parity_bit(par_p), .stop_bit(stop_p),
        .recieved_flag(flag_p), .rx_busy(busy_p)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .OVERSAMPLE(16)) dut_n (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_n),
        .raw_data(data_n), .start_bit(start_n), .parity_bit(par_n), .stop_bit(stop_n),
        .recieved_flag(flag_n), .rx_busy(busy_n)
    );

    always #5 clk = ~clk;

    // baud_tick is high one clock in four.
    initial begin
        forever begin
            @(negedge clk);
            baud_tick = (tick_div == 3);
            tick_div  = (tick_div + 1) % 4;
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_no++;
    end

    // Snapshot every frame strobe together with the tick number it followed.
    initial begin
        flag_cnt[0] = 0;
        flag_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (flag_p === 1'b1) begin
                flag_cnt[0]++;
                snap[0]      = {data_p, start_p, par_p, stop_p, busy_p};
                snap_tick[0] = tick_no;
            end
            if (flag_n === 1'b1) begin
                flag_cnt[1]++;
                snap[1]      = {data_n, start_n, par_n, stop_n, busy_n};
                snap_tick[1] = tick_no;
            end
        end
    end

    task automatic tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        @(negedge clk);
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_p = v;
        else rx_n = v;
    endtask

    task automatic drive_bit(input int which, input logic v, input logic glitch);
        set_line(which, v);
        if (glitch) begin
            repeat (7) tick();
            set_line(which, ~v);
            tick();
            set_line(which, v);
            repeat (8) tick();
        end else begin
            repeat (16) tick();
        end
    endtask

    // The stop bit is sampled 8 ticks into the last bit period of the frame.
    task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                              input logic stp, input int low_ticks, input int glitch_bit,
                              output int exp_tick);
        exp_tick = tick_no + 8 + 16 * ((which == 0) ? 10 : 9);
        set_line(which, 1'b0);
        repeat (low_ticks) tick();
        set_line(which, 1'b1);
        repeat (16 - low_ticks) tick();
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], (i == glitch_bit));
        if (which == 0) drive_bit(which, par, 1'b0);
        set_line(which, stp);
        repeat (16) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data_p, start_p, par_p, stop_p, flag_p, busy_p} !== 13'b00000000_0_0_1_0_0) begin
            errors++;
            $display("[TB] FAIL reset_p: got %h expected %h",
                     {data_p, start_p, par_p, stop_p, flag_p, busy_p}, 13'b00000000_0_0_1_0_0);
        end
        checks++;
        if ({data_n, start_n, par_n, stop_n, flag_n, busy_n} !== 13'b00000000_0_0_1_0_0) begin
            errors++;
            $display("[TB] FAIL reset_n: got %h expected %h",
                     {data_n, start_n, par_n, stop_n, flag_n, busy_n}, 13'b00000000_0_0_1_0_0);
        end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_parity_frame();
        int c0, et;
        c0 = flag_cnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b1, 16, -1, et);
        checks++;
        if (flag_cnt[0] - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL parity_flag_count: got %0d expected 1", flag_cnt[0] - c0);
        end
        checks++;
        if (snap[0] !== {8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL parity_fields: got %h expected %h", snap[0], {8'hA5, 4'b0010});
        end
        checks++;
        if (snap_tick[0] !== et) begin
            errors++;
            $display("[TB] FAIL parity_latency: got tick %0d expected tick %0d", snap_tick[0], et);
        end
        checks++;
        if (busy_p !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_busy_after: got %b expected 0", busy_p);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        int c0, et;
        words[0] = 8'h3C;
        words[1] = 8'hC3;
        for (int k = 0; k < 2; k++) begin
            c0 = flag_cnt[1];
            send_frame(1, words[k], 1'b0, 1'b1, 16, -1, et);
            checks++;
            if (flag_cnt[1] - c0 !== 1) begin
                errors++;
                $display("[TB] FAIL b2b_flag_count[%0d]: got %0d expected 1", k, flag_cnt[1] - c0);
            end
            checks++;
            if (snap[1] !== {words[k], 4'b0010}) begin
                errors++;
                $display("[TB] FAIL b2b_fields[%0d]: got %h expected %h", k, snap[1], {words[k], 4'b0010});
            end
            checks++;
            if (snap_tick[1] !== et) begin
                errors++;
                $display("[TB] FAIL b2b_latency[%0d]: got tick %0d expected tick %0d", k, snap_tick[1], et);
            end
        end
    endtask

    task automatic test_break();
        int c0, et;
        c0 = flag_cnt[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 16, -1, et);
        checks++;
        if (snap[0] !== {8'h55, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL break_fields: got %h expected %h", snap[0], {8'h55, 4'b0001});
        end
        checks++;
        if (snap_tick[0] !== et) begin
            errors++;
            $display("[TB] FAIL break_latency: got tick %0d expected tick %0d", snap_tick[0], et);
        end
        for (int b = 0; b < 3; b++) begin
            repeat (16) tick();
            checks++;
            if (busy_p !== 1'b1) begin
                errors++;
                $display("[TB] FAIL break_hold[%0d]: busy got %b expected 1", b, busy_p);
            end
        end
        set_line(0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (busy_p !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_release: busy got %b expected 0", busy_p);
        end
        repeat (20) tick();
        checks++;
        if (flag_cnt[0] - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL break_flag_count: got %0d expected 1", flag_cnt[0] - c0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0, et;
        c0 = flag_cnt[0];
        set_line(0, 1'b0);
        repeat (16) tick();
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
        repeat (4) tick();
        checks++;
        if (busy_p !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy_p);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data_p, start_p, par_p, stop_p, flag_p, busy_p} !== 13'b00000000_0_0_1_0_0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h expected %h",
                     {data_p, start_p, par_p, stop_p, flag_p, busy_p}, 13'b00000000_0_0_1_0_0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) tick();
        checks++;
        if (flag_cnt[0] - c0 !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_flag: got %0d expected 0", flag_cnt[0] - c0);
        end
        send_frame(0, 8'h81, 1'b0, 1'b1, 16, -1, et);
        checks++;
        if (flag_cnt[0] - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL midreset_next_count: got %0d expected 1", flag_cnt[0] - c0);
        end
        checks++;
        if (snap[0] !== {8'h81, 4'b0010}) begin
            errors++;
            $display("[TB] FAIL midreset_next_fields: got %h expected %h", snap[0], {8'h81, 4'b0010});
        end
        checks++;
        if (snap_tick[0] !== et) begin
            errors++;
            $display("[TB] FAIL midreset_next_latency: got tick %0d expected tick %0d", snap_tick[0], et);
        end
    endtask

    task automatic test_false_start();
        int c0, et;
        c0 = flag_cnt[0];
        send_frame(0, 8'h5A, 1'b0, 1'b1, 4, -1, et);
        checks++;
        if (flag_cnt[0] - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL false_start_count: got %0d expected 1", flag_cnt[0] - c0);
        end
        checks++;
        if (snap[0] !== {8'h5A, 4'b1010}) begin
            errors++;
            $display("[TB] FAIL false_start_fields: got %h expected %h", snap[0], {8'h5A, 4'b1010});
        end
        checks++;
        if (snap_tick[0] !== et) begin
            errors++;
            $display("[TB] FAIL false_start_latency: got tick %0d expected tick %0d", snap_tick[0], et);
        end
    endtask

    task automatic test_glitch();
        int c0, et;
        logic [7:0] exp_data;
`ifdef RX_MAJORITY_VOTE_EN
        exp_data = 8'h00;
`else
        exp_data = 8'h04;
`endif
        c0 = flag_cnt[0];
        send_frame(0, 8'h00, 1'b0, 1'b1, 16, 2, et);
        checks++;
        if (flag_cnt[0] - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL glitch_count: got %0d expected 1", flag_cnt[0] - c0);
        end
        checks++;
        if (snap[0] !== {exp_data, 4'b0010}) begin
            errors++;
            $display("[TB] FAIL glitch_fields: got %h expected %h", snap[0], {exp_data, 4'b0010});
        end
        checks++;
        if (snap_tick[0] !== et) begin
            errors++;
            $display("[TB] FAIL glitch_latency: got tick %0d expected tick %0d", snap_tick[0], et);
        end
    endtask

    task automatic test_random();
        int which, c0, et;
        logic [7:0] d;
        logic par;
        logic [11:0] exp_snap;
        for (int k = 0; k < 12; k++) begin
            which = k % 2;
            d     = 8'($urandom);
            par   = 1'($urandom);
            repeat ($urandom_range(0, 6)) tick();
            c0 = flag_cnt[which];
            send_frame(which, d, par, 1'b1, 16, -1, et);
            exp_snap = {d, 1'b0, (which == 0) ? par : 1'b0, 1'b1, 1'b0};
            checks++;
            if (flag_cnt[which] - c0 !== 1) begin
                errors++;
                $display("[TB] FAIL random_count[%0d]: got %0d expected 1", k, flag_cnt[which] - c0);
            end
            checks++;
            if (snap[which] !== exp_snap) begin
                errors++;
                $display("[TB] FAIL random_fields[%0d]: got %h expected %h", k, snap[which], exp_snap);
            end
            checks++;
            if (snap_tick[which] !== et) begin
                errors++;
                $display("[TB] FAIL random_latency[%0d]: got tick %0d expected tick %0d",
                         k, snap_tick[which], et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        test_false_start();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
